// File: rtl/swerv_types.sv
// Shared LSU types: side-effect ordering FSM state and
// default outstanding side-effect store depth.
package swerv_types;

  localparam int SE_DEPTH_DEF = 4;
  localparam int SE_CNT_W     = 4;

  typedef enum logic [1:0] {
    SE_IDLE,
    SE_BUSY,
    SE_DRAIN,
    SE_DONE
  } se_ord_state_t;

  typedef struct packed {
    logic valid;
    logic store;
    logic se;
    logic ext;
    logic freeze;
    logic flush;
  } se_dc3_t;

  function automatic logic se_commit_f(input se_dc3_t p);
    return p.valid & p.store & p.se & p.ext &
           ~p.freeze & ~p.flush;
  endfunction

endpackage

// File: rtl/lsu_se_cnt_ctl.sv
// Saturating up/down counter of outstanding side-effect
// stores, with a sticky error on under/overflow.
module lsu_se_cnt_ctl #(
  parameter int W   = 4,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         err
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_nxt;
  logic         err_set;

  always_comb begin
    cnt_nxt = cnt;
    err_set = 1'b0;
    unique case (1'b1)
      inc & ~dec: begin
        if (cnt == MAX_C) err_set = 1'b1;
        else              cnt_nxt = cnt + 1'b1;
      end
      dec & ~inc: begin
        if (cnt == '0) err_set = 1'b1;
        else           cnt_nxt = cnt - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      err <= err | err_set;
    end
  end

endmodule

// File: rtl/lsu_se_order_ctl.sv
// Orders external side-effect loads/stores against
// outstanding stores and completes side-effect fences.
module lsu_se_order_ctl
  import swerv_types::*;
#(
  parameter int SE_DEPTH = SE_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lsu_pkt_dc2_valid,
  input  logic       lsu_pkt_dc2_load,
  input  logic       is_sideeffects_dc2,
  input  logic       addr_external_dc2,
  input  logic       lsu_pkt_dc3_valid,
  input  logic       lsu_pkt_dc3_store,
  input  logic       is_sideeffects_dc3,
  input  logic       addr_external_dc3,
  input  logic       lsu_freeze_dc3,
  input  logic       flush_dc3,
  input  logic       bus_se_store_ack,
  input  logic       dec_tlu_se_fence,
  output logic       lsu_se_stall_dc2,
  output logic       lsu_se_fence_done,
  output logic       lsu_se_idle,
  output logic [3:0] lsu_se_cnt,
  output logic       lsu_se_err
);

  localparam logic [SE_CNT_W-1:0] SE_MAX =
    SE_CNT_W'(SE_DEPTH);

  se_ord_state_t       state, state_nxt;
  se_dc3_t             dc3;
  logic                se_commit;
  logic                fence_q;
  logic                fence_take;
  logic [SE_CNT_W-1:0] cnt;
  logic                cnt_zero;
  logic                cnt_full;
  logic                dc2_se;

  assign dc3 = '{
    valid:  lsu_pkt_dc3_valid,
    store:  lsu_pkt_dc3_store,
    se:     is_sideeffects_dc3,
    ext:    addr_external_dc3,
    freeze: lsu_freeze_dc3,
    flush:  flush_dc3
  };

  assign se_commit = se_commit_f(dc3);

  lsu_se_cnt_ctl #(
    .W   (SE_CNT_W),
    .MAX (SE_DEPTH)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (se_commit),
    .dec (bus_se_store_ack),
    .cnt (cnt),
    .err (lsu_se_err)
  );

  assign cnt_zero = (cnt == '0);
  assign cnt_full = (cnt == SE_MAX);

  // A fence arriving while one is already in flight merges.
  assign fence_take = dec_tlu_se_fence &
                      ((state == SE_IDLE) |
                       (state == SE_BUSY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SE_IDLE;
      fence_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      fence_q <= fence_take;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SE_IDLE: begin
        if (fence_q)       state_nxt = SE_DONE;
        else if (!cnt_zero) state_nxt = SE_BUSY;
      end
      SE_BUSY: begin
        if (fence_q)       state_nxt = SE_DRAIN;
        else if (cnt_zero) state_nxt = SE_IDLE;
      end
      SE_DRAIN: begin
        if (cnt_zero) state_nxt = SE_DONE;
      end
      SE_DONE: begin
        state_nxt = cnt_zero ? SE_IDLE : SE_BUSY;
      end
      default: state_nxt = SE_IDLE;
    endcase
  end

  assign dc2_se = lsu_pkt_dc2_valid &
                  is_sideeffects_dc2 &
                  addr_external_dc2;

  assign lsu_se_stall_dc2 =
    dc2_se &
    ((lsu_pkt_dc2_load & ~cnt_zero) |
     (~lsu_pkt_dc2_load & cnt_full) |
     (state == SE_DRAIN));

  assign lsu_se_fence_done = (state == SE_DONE);
  assign lsu_se_idle = cnt_zero & (state != SE_DRAIN);
  assign lsu_se_cnt  = 4'(cnt);

endmodule

// File: doc/lsu_se_order_ctl.md
LSU_SE_ORDER_CTL -- requirements
Module: lsu_se_order_ctl

Interface
REQ-001 The block SHALL have parameter SE_DEPTH, default 4, meaning the maximum number of outstanding external side-effect stores (legal range 2..15).
REQ-002 The block SHALL have port clk, input, 1, the single core clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port lsu_pkt_dc2_valid, input, 1, a valid LSU packet is in dc2.
REQ-005 The block SHALL have port lsu_pkt_dc2_load, input, 1, the dc2 packet is a load.
REQ-006 The block SHALL have ports is_sideeffects_dc2 and addr_external_dc2, input, 1 each, the dc2 region attributes from address check.
REQ-007 The block SHALL have port lsu_pkt_dc3_valid, input, 1, a valid LSU packet is in dc3.
REQ-008 The block SHALL have port lsu_pkt_dc3_store, input, 1, the dc3 packet is a store.
REQ-009 The block SHALL have ports is_sideeffects_dc3 and addr_external_dc3, input, 1 each, the dc3 attributes.
REQ-010 The block SHALL have port lsu_freeze_dc3, input, 1, dc3 held this cycle, so no commit.
REQ-011 The block SHALL have port flush_dc3, input, 1, the dc3 packet is killed.
REQ-012 The block SHALL have port bus_se_store_ack, input, 1, a one-cycle pulse per completed external side-effect store.
REQ-013 The block SHALL have port dec_tlu_se_fence, input, 1, a one-cycle fence request.
REQ-014 The block SHALL have port lsu_se_stall_dc2, output, 1, stall the dc2 packet.
REQ-015 The block SHALL have port lsu_se_fence_done, output, 1, a one-cycle fence completion pulse.
REQ-016 The block SHALL have port lsu_se_idle, output, 1, no side-effect stores outstanding.
REQ-017 The block SHALL have port lsu_se_cnt, output, 4, the outstanding count.
REQ-018 The block SHALL have port lsu_se_err, output, 1, a sticky protocol error.

Function
REQ-019 se_commit SHALL equal lsu_pkt_dc3_valid & lsu_pkt_dc3_store & is_sideeffects_dc3 & addr_external_dc3 & ~lsu_freeze_dc3 & ~flush_dc3.
REQ-020 The count SHALL update in the next cycle as +1 on se_commit only, -1 on bus_se_store_ack only, and unchanged when both or neither occur.
REQ-021 A decrement at count 0 SHALL hold the count at 0 and set lsu_se_err.
REQ-022 An increment at SE_DEPTH SHALL hold the count at SE_DEPTH and set lsu_se_err; lsu_se_err SHALL clear only on rst.
REQ-023 lsu_se_stall_dc2 SHALL be combinational: lsu_pkt_dc2_valid & is_sideeffects_dc2 & addr_external_dc2 & ((lsu_pkt_dc2_load & cnt!=0) | (~lsu_pkt_dc2_load & cnt==SE_DEPTH) | state==DRAIN).
REQ-024 The FSM SHALL have states IDLE (cnt==0), BUSY (cnt>0), DRAIN (fence pending) and DONE (one cycle).
REQ-025 On dec_tlu_se_fence in IDLE, the next state SHALL be DONE.
REQ-026 On dec_tlu_se_fence in BUSY, the next state SHALL be DRAIN.
REQ-027 In DRAIN, the FSM SHALL go to DONE in the cycle after the count reaches 0; commits during DRAIN SHALL still count.
REQ-028 In DONE, lsu_se_fence_done SHALL be 1, and the next state SHALL be IDLE or BUSY according to the count.
REQ-029 A fence during DRAIN or DONE SHALL be absorbed into the current fence, with no extra done pulse.
REQ-030 IDLE and BUSY transitions SHALL follow the registered count.
REQ-031 lsu_se_idle SHALL equal (cnt==0) & state!=DRAIN.
REQ-032 All outputs other than lsu_se_stall_dc2 SHALL be registered, or derived only from registered state.

Reset
REQ-033 On rst assertion, the FSM SHALL be IDLE, the count 0, lsu_se_err 0 and lsu_se_fence_done 0, and therefore lsu_se_idle 1 and lsu_se_stall_dc2 0 unless dc2 inputs force it.
REQ-034 A reset mid-DRAIN SHALL abandon the fence with no done pulse; outstanding acks arriving after reset SHALL set lsu_se_err.
REQ-035 The count SHALL be usable on the first clock edge after rst deassertion.

Structure
REQ-036 The FSM state enum se_ord_state_t and the default SE_DEPTH SHALL reside in swerv_types.
REQ-037 The saturating up/down counter SHALL be one sub-module, lsu_se_cnt_ctl, with parameters for width and maximum.
REQ-038 All flops SHALL be plain async-high-reset flops, with no clock gating.

Verification
REQ-039 Bench SHALL cover: 3 se_commit cycles followed by 3 acks -> cnt 1,2,3,2,1,0 and lsu_se_idle returns to 1.
REQ-040 Bench SHALL cover: cnt=2 with a dc2 side-effect external load -> lsu_se_stall_dc2=1 until the cycle after cnt becomes 0.
REQ-041 Bench SHALL cover: cnt=4 (SE_DEPTH=4) with a dc2 side-effect store -> stall=1, while a simultaneous commit and ack keeps cnt at 4.
REQ-042 Bench SHALL cover: a fence with cnt=0 -> lsu_se_fence_done pulses exactly 2 cycles after the request, once.
REQ-043 Bench SHALL cover: a fence with cnt=2 plus 2 spaced acks -> state DRAIN with stall asserted, and one done pulse after the second ack.
REQ-044 Bench SHALL cover: an ack at cnt=0, and commits with flush_dc3 or lsu_freeze_dc3 -> cnt unchanged and lsu_se_err=1 only for the ack.
